// File: rtl/br_miss_recover_pkg.sv
// Shared types and default sizing for branch-miss recovery.
package br_miss_recover_pkg;

   localparam int AddrWidth     = 32;
   localparam int RobDepth      = 32;
   localparam int BrFlushCycles = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      FLUSH = 2'd2,
      REDIR = 2'd3
   } BrRecState_t;

endpackage

// File: rtl/br_miss_if.sv
// Execute-report, commit and recovery-output bundle for br_miss_recover.
interface br_miss_if #(
   parameter int ADDR = 32,
   parameter int ROB  = 5
);
   logic            exe_valid;
   logic [ROB-1:0]  exe_rob_id;
   logic            exe_pred_miss_;
   logic            exe_jump_miss_;
   logic            exe_br_taken;
   logic [ADDR-1:0] exe_target;
   logic [ROB-1:0]  rob_head;
   logic            commit_valid;
   logic [ROB-1:0]  commit_rob_id;
   logic            flush;
   logic            redirect_valid;
   logic [ADDR-1:0] redirect_addr;
   logic            pred_upd_valid;
   logic            pred_upd_taken;
   logic            busy;

   modport slave (
      input  exe_valid, exe_rob_id, exe_pred_miss_, exe_jump_miss_, exe_br_taken,
             exe_target, rob_head, commit_valid, commit_rob_id,
      output flush, redirect_valid, redirect_addr, pred_upd_valid, pred_upd_taken, busy
   );

   modport master (
      output exe_valid, exe_rob_id, exe_pred_miss_, exe_jump_miss_, exe_br_taken,
             exe_target, rob_head, commit_valid, commit_rob_id,
      input  flush, redirect_valid, redirect_addr, pred_upd_valid, pred_upd_taken, busy
   );
endinterface

// File: rtl/br_miss_recover_age_cmp.sv
// Combinational ROB age compare: a_older=1 when id_a is strictly older than id_b.
module rob_age_cmp #(
   parameter int ROB = 5
) (
   input  logic [ROB-1:0] id_a,
   input  logic [ROB-1:0] id_b,
   input  logic [ROB-1:0] head,
   output logic           a_older
);
   logic [ROB-1:0] age_a;
   logic [ROB-1:0] age_b;

   // Subtraction wraps at ROB bits, giving distance from head in ring order.
   always_comb begin
      age_a   = id_a - head;
      age_b   = id_b - head;
      a_older = (age_a < age_b);
   end
endmodule

// File: rtl/br_miss_recover.sv
// Tracks the oldest outstanding branch/jump miss and, once it commits,
// drives flush, fetch redirect and predictor update.
//
// state | meaning
// IDLE  | nothing pending
// PEND  | oldest miss captured, waiting for it to commit
// FLUSH | flush held for FLUSH_CYCLES cycles
// REDIR | one-cycle fetch redirect to captured target
module br_miss_recover
   import br_miss_recover_pkg::*;
#(
   parameter int ADDR         = AddrWidth,
   parameter int ROB_DEPTH    = RobDepth,
   parameter int FLUSH_CYCLES = BrFlushCycles
) (
   input logic      clk,
   input logic      reset,
   br_miss_if.slave bus
);
   localparam int ROB   = $clog2(ROB_DEPTH);
   localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   typedef struct packed {
      logic [ROB-1:0]  rob_id;
      logic [ADDR-1:0] target;
      logic            is_jump;
      logic            taken;
   } BrMiss_t;

   BrRecState_t     state_q, state_d;
   BrMiss_t         pend_q, pend_d, new_miss;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            flush_q, flush_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [ADDR-1:0] redirect_addr_q, redirect_addr_d;
   logic            pred_upd_valid_q, pred_upd_valid_d;
   logic            pred_upd_taken_q, pred_upd_taken_d;
   logic            busy_q, busy_d;
   logic            miss_rpt;
   logic            rpt_older;
   logic            commit_hit;

   rob_age_cmp #(.ROB(ROB)) u_age (
      .id_a    (bus.exe_rob_id),
      .id_b    (pend_q.rob_id),
      .head    (bus.rob_head),
      .a_older (rpt_older)
   );

   always_comb begin
      miss_rpt   = bus.exe_valid & (~bus.exe_pred_miss_ | ~bus.exe_jump_miss_);
      commit_hit = bus.commit_valid & (bus.commit_rob_id == pend_q.rob_id);
      // A jump flag low dominates, so "both low" is classified as a jump.
      new_miss.rob_id  = bus.exe_rob_id;
      new_miss.target  = bus.exe_target;
      new_miss.is_jump = ~bus.exe_jump_miss_;
      new_miss.taken   = bus.exe_br_taken;

      state_d          = state_q;
      pend_d           = pend_q;
      cnt_d            = cnt_q;
      redirect_addr_d  = redirect_addr_q;
      pred_upd_taken_d = pred_upd_taken_q;
      pred_upd_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (miss_rpt) begin
               pend_d  = new_miss;
               state_d = PEND;
            end
         end
         PEND: begin
            // Commit wins over a same-cycle report: the report is younger and dies in the flush.
            if (commit_hit) begin
               state_d = FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES);
               if (!pend_q.is_jump) begin
                  pred_upd_valid_d = 1'b1;
                  pred_upd_taken_d = pend_q.taken;
               end
            end else if (miss_rpt && rpt_older) begin
               pend_d = new_miss;
            end
         end
         FLUSH: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d         = REDIR;
               redirect_addr_d = pend_q.target;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         REDIR: begin
            state_d = IDLE;
            pend_d  = '0;
         end
         default: state_d = IDLE;
      endcase

      flush_d          = (state_d == FLUSH);
      redirect_valid_d = (state_d == REDIR);
      busy_d           = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         pend_q           <= '0;
         cnt_q            <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_addr_q  <= '0;
         pred_upd_valid_q <= 1'b0;
         pred_upd_taken_q <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         pend_q           <= pend_d;
         cnt_q            <= cnt_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_addr_q  <= redirect_addr_d;
         pred_upd_valid_q <= pred_upd_valid_d;
         pred_upd_taken_q <= pred_upd_taken_d;
         busy_q           <= busy_d;
      end
   end

   assign bus.flush          = flush_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_addr  = redirect_addr_q;
   assign bus.pred_upd_valid = pred_upd_valid_q;
   assign bus.pred_upd_taken = pred_upd_taken_q;
   assign bus.busy           = busy_q;
endmodule

// File: doc/br_miss_recover.md
Name: br_miss_recover

Overview:
- Consumes the per-instruction branch/jump verdicts produced by the execute-stage comparison unit: ROB id, active-low pred_miss_/jump_miss_, and the resolved target.
- Keeps only the oldest outstanding misprediction and waits until that instruction commits.
- Then drives a pipeline flush, a fetch redirect and a branch-predictor update.
- Sits between the execute stage, the ROB commit port and the fetch unit.

Parameters:
ADDR, `AddrWidth, address width
ROB_DEPTH, `RobDepth, number of ROB entries (power of two)
ROB, $clog2(ROB_DEPTH), ROB id width (derived, not overridden)
FLUSH_CYCLES, 2, cycles flush is held high (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
exe_valid  in  1  execute result valid this cycle
exe_rob_id  in  ROB  ROB id of reporting instruction
exe_pred_miss_  in  1  low = conditional branch direction mispredicted
exe_jump_miss_  in  1  low = jump target mispredicted
exe_br_taken  in  1  resolved branch direction
exe_target  in  ADDR  correct next PC (resolved target or fall-through)
rob_head  in  ROB  ROB id of oldest in-flight instruction
commit_valid  in  1  an instruction commits this cycle
commit_rob_id  in  ROB  ROB id committing
flush  out  1  kill all younger in-flight state
redirect_valid  out  1  one-cycle fetch redirect strobe
redirect_addr  out  ADDR  redirect PC
pred_upd_valid  out  1  one-cycle predictor update strobe
pred_upd_taken  out  1  direction to train
busy  out  1  a miss is pending or recovery is in progress

Behaviour:
- Reset (async, active-high):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Pending registers are cleared.
- Miss report:
  - Occurs when exe_valid=1 and (exe_pred_miss_=0 or exe_jump_miss_=0).
  - If both miss flags are low, the report is treated as a jump miss.
- Age rule:
  - age(id) = (id - rob_head) mod ROB_DEPTH, computed with ROB-bit wrap-around.
  - Smaller age means older.
- FSM states: IDLE, PEND, FLUSH, REDIR.
- IDLE:
  - On a miss report, capture rob_id, target, kind (branch/jump) and taken; go to PEND.
- PEND:
  - A new report with strictly smaller age replaces the captured entry.
  - An equal id or a younger report is ignored.
  - When commit_valid=1 and commit_rob_id equals the pending id, go to FLUSH and load a counter with FLUSH_CYCLES.
  - If that commit coincides with a new report, the commit wins and the report is dropped. It is necessarily younger and is about to be flushed.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles.
  - exe reports and commits are ignored.
  - Go to REDIR when the counter reaches 1.
- REDIR:
  - One cycle with redirect_valid=1 and redirect_addr = captured target; flush=0.
  - Return to IDLE.
  - A report arriving in this cycle is ignored; fetch has not yet restarted.
- Predictor update:
  - pred_upd_valid=1 and pred_upd_taken = captured taken, for one cycle, in the same cycle PEND leaves for FLUSH.
  - Asserted only for branch-kind misses; never for jumps.
- Output timing:
  - All outputs are registered.
  - flush first goes high in the cycle after the committing edge.
  - Latency from commit to redirect_valid = FLUSH_CYCLES+1 cycles.
- busy=1 in PEND, FLUSH and REDIR.
- Reset asserted mid-FLUSH or mid-REDIR immediately drops flush and redirect_valid; no redirect is issued.
- redirect_addr and pred_upd_taken hold their last value when not strobed; reset value is 0.

Decomposition:
- Shared package / exe.svh: BrRecState_t enum (IDLE, PEND, FLUSH, REDIR) and a BrMiss_t struct {rob_id, target, is_jump, taken}.
- FLUSH_CYCLES default lives as `BrFlushCycles in cpu_config.svh.
- One natural sub-module, rob_age_cmp: combinational function that returns 1 if id A is older than id B relative to rob_head. It is reusable by the load/store queue.

Test Plan:
1. Single branch miss:
   - Stimulus: ROB_DEPTH=32, head=0, report id=5 with pred_miss_=0, taken=1, target=0x1000; commit id=5 four cycles later.
   - Response: pred_upd_valid with taken=1 in the commit cycle, flush high 2 cycles, then redirect_valid with addr 0x1000, busy cleared.
2. Older replaces younger:
   - Stimulus: head=0, report id=9 (target 0x90), then id=3 (target 0x30), then commit id=3.
   - Response: redirect to 0x30; commit of id 9 is never required.
3. Wrap-around:
   - Stimulus: head=30, pending id=31, new report id=1.
   - Response: id=1 (age 3) is ignored; pending stays 31.
   - Stimulus: with pending id=1, report id=31.
   - Response: id=31 replaces id=1.
4. Jump miss:
   - Stimulus: report id=4 with jump_miss_=0, target=0x2000; commit id=4.
   - Response: no pred_upd_valid; flush then redirect to 0x2000.
   - Stimulus: report with both flags low.
   - Response: behaves as a jump (no predictor update).
5. Simultaneous commit and report:
   - Stimulus: pending id=6; in the same cycle commit id=6 and report id=7.
   - Response: recovery for id 6 only; after REDIR, FSM is IDLE with nothing pending.
6. Reset mid-flush:
   - Stimulus: assert reset in FLUSH cycle 1.
   - Response: flush=0 asynchronously, no redirect_valid ever, busy=0, FSM IDLE after reset release.
